// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port peripheral arbiter: memory protocol
// widths and codes, FSM state encoding, wait-counter width and port indices.
package mem_port_arbiter_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 2;
  localparam int ARB_CNT_W   = 4;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID    = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ       = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE      = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = 2'd3;

  localparam logic ARB_PORT0 = 1'b0;
  localparam logic ARB_PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [MEM_COUNT_W-1:0] count;
    logic                   wr_en;
    logic [WORD_W-1:0]      wr_data;
  } mem_req_t;

  function automatic logic req_valid(input logic [MEM_COUNT_W-1:0] count);
    return count != MEM_COUNT_NONE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_grant_select.sv
// Combinational grant picker for two requesters. With ARB_ROUND_ROBIN_EN defined a
// contested grant goes to the port not granted last; otherwise port 0 always wins.
module arb_grant_select
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = ARB_PORT0;
    case (req)
      2'b10: grant = ARB_PORT1;
`ifdef ARB_ROUND_ROBIN_EN
      2'b11: grant = ~last_grant;
`else
      2'b11: grant = ARB_PORT0;
`endif
      default: grant = ARB_PORT0;
    endcase
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one peripheral port between two requesters; issues one single-cycle request and
// captures the response after PER_LATENCY cycles. ARB_ROUND_ROBIN_EN selects round-robin.
//   state | meaning
//   IDLE  | sample requests, grant one and latch it onto the peripheral port
//   ISSUE | peripheral sees the request for exactly one cycle
//   WAIT  | count down the peripheral latency, then capture data and code
//   RESP  | granted port shows the captured response for one cycle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int PER_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [ADDR_W-1:0]      i_req0_addr,
  input  logic [MEM_COUNT_W-1:0] i_req0_count,
  input  logic                   i_req0_wr_en,
  input  logic [WORD_W-1:0]      i_req0_wr_data,
  output logic [WORD_W-1:0]      o_res0_rd_data,
  output logic [MEM_CODE_W-1:0]  o_res0_code,
  input  logic [ADDR_W-1:0]      i_req1_addr,
  input  logic [MEM_COUNT_W-1:0] i_req1_count,
  input  logic                   i_req1_wr_en,
  input  logic [WORD_W-1:0]      i_req1_wr_data,
  output logic [WORD_W-1:0]      o_res1_rd_data,
  output logic [MEM_CODE_W-1:0]  o_res1_code,
  output logic [ADDR_W-1:0]      o_per_addr,
  output logic [MEM_COUNT_W-1:0] o_per_count,
  output logic                   o_per_wr_en,
  output logic [WORD_W-1:0]      o_per_wr_data,
  input  logic [WORD_W-1:0]      i_per_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_per_code,
  output logic                   o_busy
);

  localparam logic [ARB_CNT_W-1:0] CNT_LOAD = ARB_CNT_W'(PER_LATENCY - 1);

  mem_req_t   req0, req1;
  logic [1:0] req_v;
  logic       grant;
  logic       last_grant;

  arb_state_e             state_q, state_d;
  logic                   gnt_q, gnt_d;
  logic [ARB_CNT_W-1:0]   cnt_q, cnt_d;
  mem_req_t               per_q, per_d;
  logic [WORD_W-1:0]      res0_data_q, res0_data_d, res1_data_q, res1_data_d;
  logic [MEM_CODE_W-1:0]  res0_code_q, res0_code_d, res1_code_q, res1_code_d;
  logic                   busy_q, busy_d;

  assign req0  = '{addr: i_req0_addr, count: i_req0_count, wr_en: i_req0_wr_en, wr_data: i_req0_wr_data};
  assign req1  = '{addr: i_req1_addr, count: i_req1_count, wr_en: i_req1_wr_en, wr_data: i_req1_wr_data};
  assign req_v = {req_valid(i_req1_count), req_valid(i_req0_count)};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign last_grant = last_q;
`else
  assign last_grant = ARB_PORT0;
`endif

  arb_grant_select u_grant_select (
    .req        (req_v),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    per_d       = per_q;
    res0_data_d = res0_data_q;
    res0_code_d = res0_code_q;
    res1_data_d = res1_data_q;
    res1_code_d = res1_code_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|req_v) begin
          gnt_d   = grant;
          per_d   = (grant == ARB_PORT1) ? req1 : req0;
          state_d = ARB_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = grant;
`endif
        end
      end
      ARB_ISSUE: begin
        // Address and write data are left as-is; only count/wr_en mark the request.
        per_d.count = MEM_COUNT_NONE;
        per_d.wr_en = 1'b0;
        cnt_d       = CNT_LOAD;
        state_d     = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (gnt_q == ARB_PORT1) begin
            res1_data_d = i_per_rd_data;
            res1_code_d = i_per_code;
          end else begin
            res0_data_d = i_per_rd_data;
            res0_code_d = i_per_code;
          end
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        res0_data_d = '0;
        res0_code_d = MEM_CODE_INVALID;
        res1_data_d = '0;
        res1_code_d = MEM_CODE_INVALID;
        state_d     = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= ARB_PORT0;
      cnt_q       <= '0;
      per_q       <= '{addr: '0, count: MEM_COUNT_NONE, wr_en: 1'b0, wr_data: '0};
      res0_data_q <= '0;
      res0_code_q <= MEM_CODE_INVALID;
      res1_data_q <= '0;
      res1_code_q <= MEM_CODE_INVALID;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= ARB_PORT0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      res0_data_q <= res0_data_d;
      res0_code_q <= res0_code_d;
      res1_data_q <= res1_data_d;
      res1_code_q <= res1_code_d;
      busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign o_per_addr     = per_q.addr;
  assign o_per_count    = per_q.count;
  assign o_per_wr_en    = per_q.wr_en;
  assign o_per_wr_data  = per_q.wr_data;
  assign o_res0_rd_data = res0_data_q;
  assign o_res0_code    = res0_code_q;
  assign o_res1_rd_data = res1_data_q;
  assign o_res1_code    = res1_code_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset/latency sequences, and a
// randomized run checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LAT = 1;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata, per_data;
  logic [1:0]  r0_count, r1_count, per_code;
  logic        r0_wr, r1_wr;
  logic [31:0] res0_data, res1_data, per_addr, per_wdata;
  logic [1:0]  res0_code, res1_code, per_count;
  logic        per_wr, busy;

  logic [31:0] l3_addr, l3_pdata;
  logic [1:0]  l3_count, l3_pcode;
  logic [31:0] l3_res0_data, l3_res1_data, l3_per_addr, l3_per_wdata;
  logic [1:0]  l3_res0_code, l3_res1_code, l3_per_count;
  logic        l3_per_wr, l3_busy;

  int checks = 0;
  int failures = 0;
  int cur = 0;
  logic tb_last = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cur <= cur + 1;

  mem_port_arbiter #(.PER_LATENCY(LAT)) u_dut (
    .clk(clk), .aresetn(aresetn),
    .i_req0_addr(r0_addr), .i_req0_count(r0_count), .i_req0_wr_en(r0_wr), .i_req0_wr_data(r0_wdata),
    .o_res0_rd_data(res0_data), .o_res0_code(res0_code),
    .i_req1_addr(r1_addr), .i_req1_count(r1_count), .i_req1_wr_en(r1_wr), .i_req1_wr_data(r1_wdata),
    .o_res1_rd_data(res1_data), .o_res1_code(res1_code),
    .o_per_addr(per_addr), .o_per_count(per_count), .o_per_wr_en(per_wr), .o_per_wr_data(per_wdata),
    .i_per_rd_data(per_data), .i_per_code(per_code), .o_busy(busy)
  );

  mem_port_arbiter #(.PER_LATENCY(3)) u_dut_lat3 (
    .clk(clk), .aresetn(aresetn),
    .i_req0_addr(l3_addr), .i_req0_count(l3_count), .i_req0_wr_en(1'b0), .i_req0_wr_data(32'h0),
    .o_res0_rd_data(l3_res0_data), .o_res0_code(l3_res0_code),
    .i_req1_addr(32'h0), .i_req1_count(MEM_COUNT_NONE), .i_req1_wr_en(1'b0), .i_req1_wr_data(32'h0),
    .o_res1_rd_data(l3_res1_data), .o_res1_code(l3_res1_code),
    .o_per_addr(l3_per_addr), .o_per_count(l3_per_count), .o_per_wr_en(l3_per_wr),
    .o_per_wr_data(l3_per_wdata),
    .i_per_rd_data(l3_pdata), .i_per_code(l3_pcode), .o_busy(l3_busy)
  );

  typedef struct {
    logic [1:0]  c0; logic [31:0] a0; logic w0; logic [31:0] d0;
    logic [1:0]  c1; logic [31:0] a1; logic w1; logic [31:0] d1;
    logic [31:0] pdata; logic [1:0] pcode;
    logic        first_fixed;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cur);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic p, input logic [1:0] c, input logic [31:0] a,
                         input logic w, input logic [31:0] d);
    if (p) begin r1_count = c; r1_addr = a; r1_wr = w; r1_wdata = d; end
    else   begin r0_count = c; r0_addr = a; r0_wr = w; r0_wdata = d; end
  endtask

  task automatic garbage_per();
    per_data = $urandom;
    per_code = MEM_CODE_READ;
  endtask

  task automatic check_res_idle(input string tag);
    check({tag, "_res0_code"}, 32'(res0_code), 32'(MEM_CODE_INVALID));
    check({tag, "_res0_data"}, res0_data, 32'h0);
    check({tag, "_res1_code"}, 32'(res1_code), 32'(MEM_CODE_INVALID));
    check({tag, "_res1_data"}, res1_data, 32'h0);
  endtask

  // Entered at the start of the cycle in which port p is sampled; leaves at the negedge
  // of the cycle after its response, with port p's request dropped.
  task automatic serve(input logic p, input logic [31:0] pdata, input logic [1:0] pcode);
    logic [1:0]  c;
    logic [31:0] a, d;
    logic        w;
    c = p ? r1_count : r0_count;
    a = p ? r1_addr : r0_addr;
    w = p ? r1_wr : r0_wr;
    d = p ? r1_wdata : r0_wdata;
    next_cycle();
    garbage_per();
    @(negedge clk);
    check("issue_count", 32'(per_count), 32'(c));
    check("issue_addr", per_addr, a);
    check("issue_wr_en", 32'(per_wr), 32'(w));
    check("issue_wr_data", per_wdata, d);
    check("issue_busy", 32'(busy), 32'd1);
    next_cycle();
    per_data = pdata;
    per_code = pcode;
    @(negedge clk);
    check("wait_count", 32'(per_count), 32'(MEM_COUNT_NONE));
    check("wait_wr_en", 32'(per_wr), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    check_res_idle("wait");
    next_cycle();
    garbage_per();
    @(negedge clk);
    check("resp_code", 32'(p ? res1_code : res0_code), 32'(pcode));
    check("resp_data", p ? res1_data : res0_data, pdata);
    check("resp_other_code", 32'(p ? res0_code : res1_code), 32'(MEM_CODE_INVALID));
    check("resp_other_data", p ? res0_data : res1_data, 32'h0);
    check("resp_busy", 32'(busy), 32'd1);
    next_cycle();
    set_req(p, MEM_COUNT_NONE, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check_res_idle("after");
    check("after_busy", 32'(busy), 32'd0);
    tb_last = p;
  endtask

  task automatic run_vec(input vec_t v);
    logic both, first;
    both  = (v.c0 != MEM_COUNT_NONE) && (v.c1 != MEM_COUNT_NONE);
    first = (RR && both) ? ~tb_last : v.first_fixed;
    set_req(1'b0, v.c0, v.a0, v.w0, v.d0);
    set_req(1'b1, v.c1, v.a1, v.w1, v.d1);
    garbage_per();
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    serve(first, v.pdata, v.pcode);
    if (both) serve(~first, ~v.pdata, v.pcode);
    next_cycle();
  endtask

  // Peripheral behaviour used by the random run: response is a pure function of the request.
  task automatic periph(input logic [31:0] a, input logic [1:0] c, input logic w,
                        output logic [31:0] d, output logic [1:0] code);
    logic mis;
    mis = (c == MEM_COUNT_HALF && a[0]) || (c == MEM_COUNT_WORD && a[1:0] != 2'b00);
    d = mis ? 32'h0 : ((a * 32'h0001_0003) ^ 32'h5A5A_0000);
    if (mis)                code = MEM_CODE_MISALIGNED;
    else if (a[7:4] == 4'hF) code = MEM_CODE_INVALID;
    else                    code = w ? MEM_CODE_WRITE : MEM_CODE_READ;
  endtask

  task automatic rand_req(input logic p);
    set_req(p, 2'($urandom_range(1, 3)), 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            $urandom);
  endtask

  task automatic run_random(input int ncyc);
    bit          m_active;
    int          m_start, m_free;
    logic        m_port, m_last, g;
    logic [1:0]  s_count, e_code, pc;
    logic [31:0] s_addr, s_wdata, e_data, pd;
    logic        s_wr, v0, v1, resp;
    m_active = 0; m_start = -100; m_free = cur; m_last = 1'b0;
    s_count = '0; s_addr = '0; s_wdata = '0; s_wr = 1'b0; e_data = '0; e_code = '0; m_port = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (m_active && m_port == 1'(p) && cur - 1 == m_start + 2 + LAT) begin
          if ($urandom_range(0, 1) == 1) rand_req(1'(p));
          else set_req(1'(p), MEM_COUNT_NONE, 32'h0, 1'b0, 32'h0);
        end else if ((p == 0 ? r0_count : r1_count) == MEM_COUNT_NONE && $urandom_range(0, 9) < 3) begin
          rand_req(1'(p));
        end
      end
      if (m_active && cur == m_start + 1 + LAT) begin
        periph(s_addr, s_count, s_wr, pd, pc);
        per_data = pd;
        per_code = pc;
      end else begin
        garbage_per();
      end
      @(negedge clk);
      if (cur >= m_free) begin
        m_active = 0;
        v0 = (r0_count != MEM_COUNT_NONE);
        v1 = (r1_count != MEM_COUNT_NONE);
        if (v0 || v1) begin
          g = (v0 && v1) ? (RR ? ~m_last : 1'b0) : v1;
          s_count = g ? r1_count : r0_count;
          s_addr  = g ? r1_addr : r0_addr;
          s_wr    = g ? r1_wr : r0_wr;
          s_wdata = g ? r1_wdata : r0_wdata;
          periph(s_addr, s_count, s_wr, e_data, e_code);
          m_port = g; m_last = g; m_active = 1; m_start = cur; m_free = cur + 3 + LAT;
        end
      end
      if (m_active && cur == m_start + 1) begin
        check("rnd_per_count", 32'(per_count), 32'(s_count));
        check("rnd_per_addr", per_addr, s_addr);
        check("rnd_per_wr_en", 32'(per_wr), 32'(s_wr));
        check("rnd_per_wr_data", per_wdata, s_wdata);
      end else begin
        check("rnd_per_count_none", 32'(per_count), 32'(MEM_COUNT_NONE));
        check("rnd_per_wr_en_low", 32'(per_wr), 32'd0);
      end
      check("rnd_busy", 32'(busy), 32'(m_active && cur > m_start && cur <= m_start + 2 + LAT));
      resp = m_active && cur == m_start + 2 + LAT;
      check("rnd_res0_code", 32'(res0_code), 32'((resp && !m_port) ? e_code : MEM_CODE_INVALID));
      check("rnd_res0_data", res0_data, (resp && !m_port) ? e_data : 32'h0);
      check("rnd_res1_code", 32'(res1_code), 32'((resp && m_port) ? e_code : MEM_CODE_INVALID));
      check("rnd_res1_data", res1_data, (resp && m_port) ? e_data : 32'h0);
      next_cycle();
    end
  endtask

  initial begin
    vecs[0] = '{MEM_COUNT_WORD, 32'h4, 1'b0, 32'h0, MEM_COUNT_NONE, 32'h0, 1'b0, 32'h0,
                32'hDEADBEEF, MEM_CODE_READ, 1'b0};
    vecs[1] = '{MEM_COUNT_NONE, 32'h0, 1'b0, 32'h0, MEM_COUNT_HALF, 32'h1, 1'b0, 32'h0,
                32'h0, MEM_CODE_MISALIGNED, 1'b1};
    vecs[2] = '{MEM_COUNT_WORD, 32'h8, 1'b1, 32'h12345678, MEM_COUNT_NONE, 32'h0, 1'b0, 32'h0,
                32'h0, MEM_CODE_WRITE, 1'b0};
    vecs[3] = '{MEM_COUNT_WORD, 32'h10, 1'b0, 32'h0, MEM_COUNT_WORD, 32'h20, 1'b0, 32'h0,
                32'hCAFEF00D, MEM_CODE_READ, 1'b0};
    vecs[4] = '{MEM_COUNT_NONE, 32'h0, 1'b0, 32'h0, MEM_COUNT_BYTE, 32'h3, 1'b0, 32'h0,
                32'h55, MEM_CODE_INVALID, 1'b1};
    vecs[5] = '{MEM_COUNT_BYTE, 32'h31, 1'b1, 32'hA5, MEM_COUNT_HALF, 32'h42, 1'b1, 32'h5A5A,
                32'h0, MEM_CODE_WRITE, 1'b0};

    set_req(1'b0, MEM_COUNT_NONE, 32'h0, 1'b0, 32'h0);
    set_req(1'b1, MEM_COUNT_NONE, 32'h0, 1'b0, 32'h0);
    garbage_per();
    l3_count = MEM_COUNT_NONE; l3_addr = 32'h0; l3_pdata = 32'h0; l3_pcode = MEM_CODE_READ;
    aresetn = 1'b0;

    @(negedge clk);
    check("rst_per_count", 32'(per_count), 32'(MEM_COUNT_NONE));
    check("rst_per_addr", per_addr, 32'h0);
    check("rst_per_wr_en", 32'(per_wr), 32'd0);
    check("rst_per_wr_data", per_wdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check_res_idle("rst");
    next_cycle();
    next_cycle();
    aresetn = 1'b1;
    tb_last = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted while the transaction sits in WAIT, then the held request completes.
    set_req(1'b0, MEM_COUNT_WORD, 32'h40, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    per_data = 32'h11112222; per_code = MEM_CODE_READ;
    aresetn = 1'b0;
    @(negedge clk);
    check("mid_rst_per_count", 32'(per_count), 32'(MEM_COUNT_NONE));
    check("mid_rst_per_addr", per_addr, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check_res_idle("mid_rst");
    next_cycle();
    garbage_per();
    @(negedge clk);
    check_res_idle("mid_rst_hold");
    next_cycle();
    aresetn = 1'b1;
    tb_last = 1'b0;
    @(negedge clk);
    check("rel_busy", 32'(busy), 32'd0);
    serve(1'b0, 32'h33334444, MEM_CODE_READ);
    next_cycle();

    // Latency-3 instance: stale READ codes around the one valid cycle.
    l3_count = MEM_COUNT_WORD; l3_addr = 32'h4;
    for (int t = 0; t < 8; t++) begin
      if (t == 6) l3_count = MEM_COUNT_NONE;
      l3_pdata = (t == 4) ? 32'h0BADF00D : $urandom;
      l3_pcode = MEM_CODE_READ;
      @(negedge clk);
      check("lat3_per_count", 32'(l3_per_count), 32'((t == 1) ? MEM_COUNT_WORD : MEM_COUNT_NONE));
      check("lat3_busy", 32'(l3_busy), 32'(t >= 1 && t <= 5));
      check("lat3_res0_code", 32'(l3_res0_code), 32'((t == 5) ? MEM_CODE_READ : MEM_CODE_INVALID));
      check("lat3_res0_data", l3_res0_data, (t == 5) ? 32'h0BADF00D : 32'h0);
      check("lat3_res1_code", 32'(l3_res1_code), 32'(MEM_CODE_INVALID));
      next_cycle();
    end

    aresetn = 1'b0;
    set_req(1'b0, MEM_COUNT_NONE, 32'h0, 1'b0, 32'h0);
    set_req(1'b1, MEM_COUNT_NONE, 32'h0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    aresetn = 1'b1;
    run_random(1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
